keypad_scan_ctrl: RTL and testbench



---
 rtl/keypad_scan_ctrl_if.sv | 23 ++
 rtl/keypad_scan_ctrl.sv | 215 +++++++++++++++++++++
 tb/tb_keypad_scan_ctrl.sv | 219 +++++++++++++++++++++
 3 files changed

// File: rtl/keypad_scan_ctrl_if.sv
// CPU-side event port of the keypad scanner: committed key state, the
// event FIFO head with its pop strobe, and the sticky overflow flag.
interface keypad_scan_ctrl_if;
    logic [15:0] KEYS;
    logic        EV_VALID;
    logic [3:0]  EV_CODE;
    logic        EV_PRESS;
    logic        EV_RD;
    logic        OVF;
    logic        OVF_CLR;

    // Scanner side: produces events, consumes pop/clear strobes.
    modport master (
        output KEYS, EV_VALID, EV_CODE, EV_PRESS, OVF,
        input  EV_RD, OVF_CLR
    );

    // Reader side (MCS-51 glue logic).
    modport slave (
        input  KEYS, EV_VALID, EV_CODE, EV_PRESS, OVF,
        output EV_RD, OVF_CLR
    );
endinterface

// File: rtl/keypad_scan_ctrl.sv
// 4x4 active-low keypad scanner. One column is driven low at a time, the
// synchronized rows are captured into a frame snapshot, whole frames are
// debounced against each other, and press/release events are queued in a
// small first-word fall-through FIFO.
module keypad_scan_ctrl #(
    parameter int unsigned SETTLE     = 4,
    parameter int unsigned STABLE     = 2,
    parameter int unsigned FIFO_DEPTH = 4
) (
    input  logic                CLK,
    input  logic                nRST,
    input  logic [3:0]          ROW,
    output logic [3:0]          COL,
    keypad_scan_ctrl_if.master  ev
);

    localparam int unsigned SetW = $clog2(SETTLE + 1);
    localparam int unsigned StW  = $clog2(STABLE + 1);
    localparam int unsigned PtrW = $clog2(FIFO_DEPTH);

    typedef enum logic [1:0] {StDrive, StSample, StCompare, StEmit} state_e;

    state_e            state_q, state_d;
    logic [1:0]        col_idx_q, col_idx_d;
    logic [SetW-1:0]   settle_q, settle_d;
    logic [3:0]        key_idx_q, key_idx_d;

    logic [3:0]        row_meta_q, row_sync_q;
    logic [15:0]       snap_q, snap_d;
    logic [15:0]       prev_q, prev_d;
    logic [StW-1:0]    stable_q, stable_d;
    logic [15:0]       keys_q, keys_d;

    logic [4:0]        mem_q [FIFO_DEPTH];
    logic [4:0]        mem_d [FIFO_DEPTH];
    logic [PtrW:0]     wr_ptr_q, wr_ptr_d;
    logic [PtrW:0]     rd_ptr_q, rd_ptr_d;
    logic              ovf_q, ovf_d;

    logic [3:0]        col_drive;
    logic              do_sample, do_compare, do_emit;
    logic              fifo_empty, fifo_full, pop, push, fifo_wr;
    logic [4:0]        head;

    // Two-flop synchronizer for the asynchronous row pins.
    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            row_meta_q <= 4'hF;
            row_sync_q <= 4'hF;
        end else begin
            row_meta_q <= ROW;
            row_sync_q <= row_meta_q;
        end
    end

    // FSM state register with its column/settle/key counters.
    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            state_q   <= StDrive;
            col_idx_q <= 2'd0;
            settle_q  <= '0;
            key_idx_q <= 4'd0;
        end else begin
            state_q   <= state_d;
            col_idx_q <= col_idx_d;
            settle_q  <= settle_d;
            key_idx_q <= key_idx_d;
        end
    end

    // FSM next state: settle, sample each column, compare, walk 16 keys.
    always_comb begin
        state_d   = state_q;
        col_idx_d = col_idx_q;
        settle_d  = settle_q;
        key_idx_d = key_idx_q;
        unique case (state_q)
            StDrive: begin
                if (settle_q == SetW'(SETTLE - 1)) begin
                    state_d = StSample;
                end else begin
                    settle_d = settle_q + SetW'(1);
                end
            end
            StSample: begin
                if (col_idx_q == 2'd3) begin
                    state_d = StCompare;
                end else begin
                    col_idx_d = col_idx_q + 2'd1;
                    settle_d  = '0;
                    state_d   = StDrive;
                end
            end
            StCompare: begin
                key_idx_d = 4'd0;
                state_d   = StEmit;
            end
            StEmit: begin
                key_idx_d = key_idx_q + 4'd1;
                if (key_idx_q == 4'd15) begin
                    col_idx_d = 2'd0;
                    settle_d  = '0;
                    state_d   = StDrive;
                end
            end
            default: state_d = StDrive;
        endcase
    end

    // FSM outputs: column drive and per-state datapath strobes.
    always_comb begin
        col_drive  = 4'hF;
        do_sample  = 1'b0;
        do_compare = 1'b0;
        do_emit    = 1'b0;
        unique case (state_q)
            StDrive:   col_drive = ~(4'b0001 << col_idx_q);
            StSample: begin
                col_drive = ~(4'b0001 << col_idx_q);
                do_sample = 1'b1;
            end
            StCompare: do_compare = 1'b1;
            StEmit:    do_emit    = 1'b1;
            default:   col_drive  = 4'hF;
        endcase
    end

    // The reset state decodes to column 0, so reset itself must float the columns.
    assign COL = nRST ? col_drive : 4'hF;

    // Snapshot capture, frame-to-frame debounce and per-key commit.
    always_comb begin
        snap_d   = snap_q;
        prev_d   = prev_q;
        stable_d = stable_q;
        keys_d   = keys_q;
        push     = 1'b0;
        if (do_sample) begin
            snap_d[{col_idx_q, 2'b00} +: 4] = ~row_sync_q;
        end
        if (do_compare) begin
            prev_d = snap_q;
            if (snap_q == prev_q) begin
                stable_d = (stable_q == StW'(STABLE)) ? stable_q : stable_q + StW'(1);
            end else begin
                stable_d = '0;
            end
        end
        if (do_emit && (stable_q == StW'(STABLE)) &&
            (snap_q[key_idx_q] != keys_q[key_idx_q])) begin
            push              = 1'b1;
            keys_d[key_idx_q] = snap_q[key_idx_q];
        end
    end

    assign fifo_empty = (wr_ptr_q == rd_ptr_q);
    assign fifo_full  = (wr_ptr_q[PtrW] != rd_ptr_q[PtrW]) &&
                        (wr_ptr_q[PtrW-1:0] == rd_ptr_q[PtrW-1:0]);
    assign pop        = ev.EV_RD && !fifo_empty;
    // A pop frees the slot the same cycle, so full+pop still accepts a push.
    assign fifo_wr    = push && (!fifo_full || pop);

    // Event FIFO pointers, storage and sticky overflow flag.
    always_comb begin
        mem_d    = mem_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        ovf_d    = ovf_q;
        if (fifo_wr) begin
            mem_d[wr_ptr_q[PtrW-1:0]] = {key_idx_q, snap_q[key_idx_q]};
            wr_ptr_d = wr_ptr_q + (PtrW + 1)'(1);
        end
        if (pop) begin
            rd_ptr_d = rd_ptr_q + (PtrW + 1)'(1);
        end
        if (push && !fifo_wr) begin
            ovf_d = 1'b1;
        end else if (ev.OVF_CLR) begin
            ovf_d = 1'b0;
        end
    end

    // Debounce and FIFO state registers.
    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            snap_q   <= '0;
            prev_q   <= '0;
            stable_q <= '0;
            keys_q   <= '0;
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            ovf_q    <= 1'b0;
            for (int i = 0; i < FIFO_DEPTH; i++) begin
                mem_q[i] <= '0;
            end
        end else begin
            snap_q   <= snap_d;
            prev_q   <= prev_d;
            stable_q <= stable_d;
            keys_q   <= keys_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            ovf_q    <= ovf_d;
            mem_q    <= mem_d;
        end
    end

    assign head        = mem_q[rd_ptr_q[PtrW-1:0]];
    assign ev.KEYS     = keys_q;
    assign ev.EV_VALID = !fifo_empty;
    assign ev.EV_CODE  = fifo_empty ? 4'd0 : head[4:1];
    assign ev.EV_PRESS = fifo_empty ? 1'b0 : head[0];
    assign ev.OVF      = ovf_q;

endmodule

// File: tb/tb_keypad_scan_ctrl.sv
// Directed bench for keypad_scan_ctrl with a combinational 4x4 switch-matrix
// model. Cycle 0 is the first clock period after reset release; every frame
// is 37 cycles (4 x 5 column cycles, 1 compare, 16 emit).
module tb_keypad_scan_ctrl;

    logic        CLK;
    logic        nRST;
    logic [3:0]  ROW;
    logic [3:0]  COL;
    logic [15:0] pressed;

    int n_cmp  = 0;
    int n_fail = 0;
    int cyc    = 0;

    keypad_scan_ctrl_if ev ();

    keypad_scan_ctrl #(
        .SETTLE     (4),
        .STABLE     (2),
        .FIFO_DEPTH (4)
    ) dut (
        .CLK  (CLK),
        .nRST (nRST),
        .ROW  (ROW),
        .COL  (COL),
        .ev   (ev)
    );

    initial begin
        CLK = 1'b0;
        forever #5 CLK = ~CLK;
    end

    // Switch matrix: a closed key pulls its row low while its column is driven low.
    always_comb begin
        ROW = 4'hF;
        for (int c = 0; c < 4; c++) begin
            for (int r = 0; r < 4; r++) begin
                if (pressed[c*4+r] && !COL[c]) ROW[r] = 1'b0;
            end
        end
    end

    function automatic int f(input int n, input int c);
        return n * 37 + c;
    endfunction

    task automatic step_to(input int target);
        while (cyc < target) begin
            @(negedge CLK);
            cyc++;
        end
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic check_head(input string tag, input logic [3:0] code, input logic press);
        check({tag, "_valid"}, 32'(ev.EV_VALID), 32'd1);
        check({tag, "_code"}, 32'(ev.EV_CODE), 32'(code));
        check({tag, "_press"}, 32'(ev.EV_PRESS), 32'(press));
    endtask

    task automatic pop_one();
        ev.EV_RD = 1'b1;
        step_to(cyc + 1);
        ev.EV_RD = 1'b0;
    endtask

    initial begin
        logic [3:0] e;
        nRST       = 1'b0;
        pressed    = 16'h0000;
        ev.EV_RD   = 1'b0;
        ev.OVF_CLR = 1'b0;

        // Reset values.
        repeat (3) @(negedge CLK);
        check("rst_col", 32'(COL), 32'hF);
        check("rst_keys", 32'(ev.KEYS), 32'h0);
        check("rst_valid", 32'(ev.EV_VALID), 32'h0);
        check("rst_code", 32'(ev.EV_CODE), 32'h0);
        check("rst_press", 32'(ev.EV_PRESS), 32'h0);
        check("rst_ovf", 32'(ev.OVF), 32'h0);

        @(posedge CLK);
        #1 nRST = 1'b1;
        @(negedge CLK);
        cyc = 0;

        // 1: idle scan pattern over one full frame.
        for (int c = 0; c < 37; c++) begin
            step_to(f(0, c));
            e = (c < 20) ? ~(4'b0001 << (c / 5)) : 4'hF;
            check("idle_col", 32'(COL), 32'(e));
        end
        step_to(f(1, 0));
        check("frame1_col", 32'(COL), 32'hE);
        step_to(f(1, 20));
        check("idle_valid", 32'(ev.EV_VALID), 32'h0);
        check("idle_keys", 32'(ev.KEYS), 32'h0);

        // 2: press key 6 from frame 2; committed in frame 4 at emit index 6.
        pressed[6] = 1'b1;
        step_to(f(3, 36));
        check("p6_early_valid", 32'(ev.EV_VALID), 32'h0);
        step_to(f(4, 27));
        check("p6_pre_valid", 32'(ev.EV_VALID), 32'h0);
        check("p6_pre_keys", 32'(ev.KEYS), 32'h0);
        step_to(f(4, 28));
        check_head("p6", 4'd6, 1'b1);
        check("p6_keys", 32'(ev.KEYS), 32'h0040);
        step_to(f(4, 30));
        pop_one();
        check("p6_popped", 32'(ev.EV_VALID), 32'h0);

        // 3: release key 6 from frame 6; event in frame 8.
        step_to(f(5, 20));
        pressed[6] = 1'b0;
        step_to(f(8, 27));
        check("r6_pre_valid", 32'(ev.EV_VALID), 32'h0);
        check("r6_pre_keys", 32'(ev.KEYS), 32'h0040);
        step_to(f(8, 28));
        check_head("r6", 4'd6, 1'b0);
        check("r6_keys", 32'(ev.KEYS), 32'h0);
        step_to(f(8, 30));
        pop_one();

        // 4: key 9 bounces every frame for frames 9..18, then held from frame 19.
        for (int i = 0; i < 10; i++) begin
            step_to(f(8 + i, 20));
            pressed[9] = (i % 2 == 0);
            step_to(f(8 + i, 36));
            check("bounce_valid", 32'(ev.EV_VALID), 32'h0);
            check("bounce_keys", 32'(ev.KEYS), 32'h0);
        end
        step_to(f(18, 20));
        pressed[9] = 1'b1;
        step_to(f(20, 36));
        check("p9_early_valid", 32'(ev.EV_VALID), 32'h0);
        step_to(f(21, 30));
        check("p9_pre_valid", 32'(ev.EV_VALID), 32'h0);
        step_to(f(21, 31));
        check_head("p9", 4'd9, 1'b1);
        check("p9_keys", 32'(ev.KEYS), 32'h0200);
        step_to(f(21, 33));
        pop_one();
        step_to(f(21, 35));
        pressed[9] = 1'b0;
        step_to(f(24, 31));
        check_head("r9", 4'd9, 1'b0);
        step_to(f(24, 33));
        pop_one();
        check("r9_popped", 32'(ev.EV_VALID), 32'h0);

        // 5: five keys at once, no reads: fourth push fills, fifth is dropped.
        step_to(f(24, 35));
        pressed = 16'h8429;
        step_to(f(27, 22));
        check_head("ovf_first", 4'd0, 1'b1);
        step_to(f(27, 36));
        check("ovf_pre", 32'(ev.OVF), 32'h0);
        check("ovf_pre_keys", 32'(ev.KEYS), 32'h0429);
        step_to(f(28, 0));
        check("ovf_set", 32'(ev.OVF), 32'h1);
        check("ovf_keys", 32'(ev.KEYS), 32'h8429);
        check_head("ovf_head", 4'd0, 1'b1);
        step_to(f(28, 2));
        check("ovf_sticky", 32'(ev.OVF), 32'h1);
        ev.OVF_CLR = 1'b1;
        step_to(f(28, 3));
        ev.OVF_CLR = 1'b0;
        check("ovf_clr", 32'(ev.OVF), 32'h0);

        // 6: release key 15; its push lands while full and popped in the same cycle.
        step_to(f(28, 20));
        pressed[15] = 1'b0;
        step_to(f(31, 36));
        check("sim_pre_ovf", 32'(ev.OVF), 32'h0);
        check_head("sim_pre_head", 4'd0, 1'b1);
        ev.EV_RD = 1'b1;
        step_to(f(32, 0));
        ev.EV_RD = 1'b0;
        check("sim_ovf", 32'(ev.OVF), 32'h0);
        check("sim_keys", 32'(ev.KEYS), 32'h0429);
        check_head("sim_q0", 4'd3, 1'b1);
        pop_one();
        check_head("sim_q1", 4'd5, 1'b1);
        pop_one();
        check_head("sim_q2", 4'd10, 1'b1);
        pop_one();
        check_head("sim_q3", 4'd15, 1'b0);

        // Reset asserted mid-emit clears everything without a clock edge.
        step_to(f(32, 25));
        nRST = 1'b0;
        #1;
        check("mid_rst_col", 32'(COL), 32'hF);
        check("mid_rst_keys", 32'(ev.KEYS), 32'h0);
        check("mid_rst_valid", 32'(ev.EV_VALID), 32'h0);
        check("mid_rst_code", 32'(ev.EV_CODE), 32'h0);
        check("mid_rst_press", 32'(ev.EV_PRESS), 32'h0);
        check("mid_rst_ovf", 32'(ev.OVF), 32'h0);
        @(posedge CLK);
        #1 nRST = 1'b1;
        @(negedge CLK);
        check("post_rst_col", 32'(COL), 32'hE);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
